comp_nbit_serial: RTL

//  Bit-serial, MSB-first magnitude comparator for WIDTH-bit operands. It is the

---
 rtl/comp_pkg.sv | 26 ++
 rtl/comp1bit.sv | 22 ++
 rtl/comp_nbit_serial.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// -----------------------------------------------------------------------------
// comp_pkg
// Shared types and constants for the bit-serial magnitude comparator.
//   state_t  : scan controller states (IDLE, SHIFT, DONE), 2-bit encoding
//   CMP_*    : result flag encodings, packed as {gt, eq, lt}
// -----------------------------------------------------------------------------
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Result flags are kept packed as {gt, eq, lt}; exactly one bit set after a
    // completed compare, all clear before the first one.
    localparam logic [2:0] CMP_NONE = 3'b000;
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_EQ   = 3'b010;
    localparam logic [2:0] CMP_LT   = 3'b001;

    localparam int FLAG_GT_BIT = 2;
    localparam int FLAG_EQ_BIT = 1;
    localparam int FLAG_LT_BIT = 0;

endpackage

// File: rtl/comp1bit.sv
// -----------------------------------------------------------------------------
// comp1bit
// Combinational one-bit magnitude compare slice (unsigned sense).
// Ports:
//   a, b  in   operand bits
//   gt    out  a > b  (a=1, b=0)
//   eq    out  a == b
//   lt    out  a < b  (a=0, b=1)
// -----------------------------------------------------------------------------
module comp1bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic eq,
    output logic lt
);

    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/comp_nbit_serial.sv
// -----------------------------------------------------------------------------
// comp_nbit_serial
// Bit-serial, MSB-first magnitude comparator for WIDTH-bit operands. A start
// request in IDLE or DONE latches A and B and scans one bit per clock from the
// MSB down, stopping at the first differing bit. done pulses for one cycle when
// the result flags have been updated; the flags then hold until the next
// accepted start.
//
// Parameters:
//   WIDTH  operand width in bits (>= 2)
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   compare request, honoured only in IDLE or DONE
//   A, B   in   operands, captured on an accepted start
//   busy   out  high while scanning
//   done   out  one-cycle pulse, flags valid/updated
//   AgB    out  A > B
//   AeB    out  A == B
//   AlB    out  A < B
// Configuration:
//   COMP_SIGNED_CMP_EN  when defined, operands are two's complement: the sense
//                       of the MSB comparison is inverted. Lower bits compare
//                       unsigned either way.
// -----------------------------------------------------------------------------
module comp_nbit_serial
    import comp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AgB,
    output logic             AeB,
    output logic             AlB
);

    localparam int              CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] IDX_MSB = CNT_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [CNT_W-1:0] idx_reg, idx_next;
    logic [2:0]       flags_reg, flags_next;

    logic slice_gt, slice_eq, slice_lt;
    logic bit_gt, bit_lt;

    // Single slice, fed with the bit currently under the scan index.
    comp1bit u_slice (
        .a  (a_reg[idx_reg]),
        .b  (b_reg[idx_reg]),
        .gt (slice_gt),
        .eq (slice_eq),
        .lt (slice_lt)
    );

`ifdef COMP_SIGNED_CMP_EN
    // Two's complement: a set sign bit means the smaller value, so the MSB
    // decision is swapped. All lower bits keep their unsigned weight.
    logic at_msb;
    assign at_msb = (idx_reg == IDX_MSB);
    assign bit_gt = at_msb ? slice_lt : slice_gt;
    assign bit_lt = at_msb ? slice_gt : slice_lt;
`else
    assign bit_gt = slice_gt;
    assign bit_lt = slice_lt;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            idx_reg   <= '0;
            flags_reg <= CMP_NONE;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            idx_reg   <= idx_next;
            flags_reg <= flags_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        idx_next   = idx_reg;
        flags_next = flags_reg;

        unique case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    // DONE accepts start as well, giving back-to-back compares
                    // with no idle cycle in between.
                    state_next = SHIFT;
                    a_next     = A;
                    b_next     = B;
                    idx_next   = IDX_MSB;
                    flags_next = CMP_NONE;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately ignored here; operands are already latched.
                if (bit_gt) begin
                    flags_next = CMP_GT;
                    state_next = DONE;
                end else if (bit_lt) begin
                    flags_next = CMP_LT;
                    state_next = DONE;
                end else if (slice_eq && (idx_reg == '0)) begin
                    flags_next = CMP_EQ;
                    state_next = DONE;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign AgB  = flags_reg[FLAG_GT_BIT];
    assign AeB  = flags_reg[FLAG_EQ_BIT];
    assign AlB  = flags_reg[FLAG_LT_BIT];

endmodule
